// File: rtl/regfile_rw_if.sv
// Bus bundle for regfile_rw: write port, read-address capture, read data,
// flat register bus and write counter.
interface regfile_rw_if #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned SEL       = 5
);
    logic                            Wen;
    logic [SEL-1:0]                  Waddr;
    logic [BUS_WIDTH-1:0]            Wdata;
    logic [BUS_WIDTH/8-1:0]          Wbe;
    logic [SEL-1:0]                  Raddr1;
    logic [SEL-1:0]                  Raddr2;
    logic                            Ren;
    logic [BUS_WIDTH-1:0]            Rdata1;
    logic [BUS_WIDTH-1:0]            Rdata2;
    logic [BUS_WIDTH*(2**SEL)-1:0]   Dout;
    logic [15:0]                     WrCount;

    modport master (
        output Wen, Waddr, Wdata, Wbe, Raddr1, Raddr2, Ren,
        input  Rdata1, Rdata2, Dout, WrCount
    );

    modport slave (
        input  Wen, Waddr, Wdata, Wbe, Raddr1, Raddr2, Ren,
        output Rdata1, Rdata2, Dout, WrCount
    );
endinterface

// File: rtl/regfile_rw.sv
// General-purpose register file: byte-enabled write port, two registered-address
// read ports with optional write-first bypass, and a flat bus of all entries.
module regfile_rw #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned SEL       = 5,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned BYPASS    = 1
) (
    input logic          Clk,
    input logic          Reset,
    regfile_rw_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << SEL;
    localparam int unsigned NBYTE = BUS_WIDTH / 8;

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [SEL-1:0]       ra1_q;
    logic [SEL-1:0]       ra2_q;
    logic [15:0]          wr_count;
    logic                 waddr_zero;
    logic                 wr_commit;
    logic [BUS_WIDTH-1:0] wr_merged;

    function automatic logic [BUS_WIDTH-1:0] merge(
        input logic [BUS_WIDTH-1:0] old_val,
        input logic [BUS_WIDTH-1:0] new_val,
        input logic [NBYTE-1:0]     be
    );
        logic [BUS_WIDTH-1:0] res;
        res = old_val;
        for (int unsigned k = 0; k < NBYTE; k++) begin
            if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    assign waddr_zero = (ZERO_REG != 0) && (bus.Waddr == '0);
    assign wr_commit  = bus.Wen && (bus.Wbe != '0) && !waddr_zero;
    assign wr_merged  = merge(mem[bus.Waddr], bus.Wdata, bus.Wbe);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            wr_count <= '0;
        end else begin
            if (wr_commit) begin
                mem[bus.Waddr] <= wr_merged;
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
            if (bus.Ren) begin
                ra1_q <= bus.Raddr1;
                ra2_q <= bus.Raddr2;
            end
        end
    end

    // Bypass forwards the merged word only when the write will really land in that entry.
    always_comb begin
        bus.Rdata1 = mem[ra1_q];
        bus.Rdata2 = mem[ra2_q];
        if (BYPASS != 0 && bus.Wen && !Reset && !waddr_zero) begin
            if (bus.Waddr == ra1_q) bus.Rdata1 = wr_merged;
            if (bus.Waddr == ra2_q) bus.Rdata2 = wr_merged;
        end
        if (ZERO_REG != 0 && ra1_q == '0) bus.Rdata1 = '0;
        if (ZERO_REG != 0 && ra2_q == '0) bus.Rdata2 = '0;
    end

    always_comb begin
        bus.Dout = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) bus.Dout[i*BUS_WIDTH +: BUS_WIDTH] = mem[i];
        end
    end

    assign bus.WrCount = wr_count;
endmodule

// File: tb/tb_regfile_rw.sv
// Self-checking bench for regfile_rw: directed scenarios plus randomized traffic
// against a behavioural model, on a bypass/zero-reg instance and a plain instance.
module tb_regfile_rw;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    regfile_rw_if #(.BUS_WIDTH(32), .SEL(5)) bus ();
    regfile_rw_if #(.BUS_WIDTH(32), .SEL(5)) nb ();

    regfile_rw #(.BUS_WIDTH(32), .SEL(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus.slave)
    );
    regfile_rw #(.BUS_WIDTH(32), .SEL(5), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .bus(nb.slave)
    );

    assign nb.Wen    = bus.Wen;
    assign nb.Waddr  = bus.Waddr;
    assign nb.Wdata  = bus.Wdata;
    assign nb.Wbe    = bus.Wbe;
    assign nb.Raddr1 = bus.Raddr1;
    assign nb.Raddr2 = bus.Raddr2;
    assign nb.Ren    = bus.Ren;

    int checks = 0;
    int failures = 0;

    // Reference model: m1 for the zero-reg/bypass instance, m0 for the plain one.
    logic [31:0] m1 [32];
    logic [31:0] m0 [32];
    logic [4:0]  ra1, ra2;
    int          cnt1, cnt0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd1(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = m1[a];
        if (bus.Wen && !Reset && bus.Waddr == a) v = merge(v, bus.Wdata, bus.Wbe);
        return v;
    endfunction

    function automatic logic [1023:0] exp_dout1();
        logic [1023:0] e;
        for (int i = 0; i < 32; i++) e[i*32 +: 32] = m1[i];
        return e;
    endfunction

    function automatic logic [1023:0] exp_dout0();
        logic [1023:0] e;
        for (int i = 0; i < 32; i++) e[i*32 +: 32] = m0[i];
        return e;
    endfunction

    task automatic drive(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic ren, input logic [4:0] r1,
                         input logic [4:0] r2);
        bus.Wen = wen; bus.Waddr = wa; bus.Wdata = wd; bus.Wbe = be;
        bus.Ren = ren; bus.Raddr1 = r1; bus.Raddr2 = r2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin m1[i] = 32'h0; m0[i] = 32'h0; end
            ra1 = 5'd0; ra2 = 5'd0; cnt1 = 0; cnt0 = 0;
        end else begin
            if (bus.Wen && bus.Wbe != 4'h0) begin
                if (bus.Waddr != 5'd0) begin
                    m1[bus.Waddr] = merge(m1[bus.Waddr], bus.Wdata, bus.Wbe);
                    if (cnt1 < 65535) cnt1++;
                end
                m0[bus.Waddr] = merge(m0[bus.Waddr], bus.Wdata, bus.Wbe);
                if (cnt0 < 65535) cnt0++;
            end
            if (bus.Ren) begin ra1 = bus.Raddr1; ra2 = bus.Raddr2; end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        checks++; if (bus.Dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", bus.Dout); end
        checks++; if (bus.Rdata1 !== 32'h0 || bus.Rdata2 !== 32'h0) begin failures++;
            $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.Rdata1, bus.Rdata2); end
        checks++; if (bus.WrCount !== 16'h0) begin failures++; $display("FAIL reset_wrcount got=%h exp=0", bus.WrCount); end
        checks++; if (nb.Dout !== '0 || nb.WrCount !== 16'h0) begin failures++;
            $display("FAIL reset_nb got_cnt=%h exp=0", nb.WrCount); end
    endtask

    task automatic test_full_write();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 5'd0);
        step();
        idle();
        checks++; if (bus.Rdata1 !== 32'hDEADBEEF) begin failures++; $display("FAIL full_rdata1 got=%h exp=deadbeef", bus.Rdata1); end
        checks++; if (bus.Dout[191:160] !== 32'hDEADBEEF) begin failures++; $display("FAIL full_dout5 got=%h exp=deadbeef", bus.Dout[191:160]); end
        checks++; if (bus.WrCount !== 16'd1) begin failures++; $display("FAIL full_wrcount got=%0d exp=1", bus.WrCount); end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0, 5'd0, 5'd0);
        step();
        idle();
        checks++; if (bus.Rdata1 !== 32'hDE22BE44) begin failures++; $display("FAIL partial_rdata1 got=%h exp=de22be44", bus.Rdata1); end
        checks++; if (bus.Dout[191:160] !== 32'hDE22BE44) begin failures++; $display("FAIL partial_dout5 got=%h exp=de22be44", bus.Dout[191:160]); end
        drive(1'b1, 5'd5, 32'h99999999, 4'h0, 1'b0, 5'd0, 5'd0);
        step();
        idle();
        checks++; if (bus.WrCount !== 16'd2 || bus.Dout[191:160] !== 32'hDE22BE44) begin failures++;
            $display("FAIL no_byte_write got_cnt=%0d got=%h exp_cnt=2 exp=de22be44", bus.WrCount, bus.Dout[191:160]); end
    endtask

    task automatic test_zero_reg();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 5'd0);
        step();
        idle();
        checks++; if (bus.Rdata1 !== 32'h0 || bus.Rdata2 !== 32'h0) begin failures++;
            $display("FAIL zero_rdata got=%h/%h exp=0/0", bus.Rdata1, bus.Rdata2); end
        checks++; if (bus.WrCount !== 16'd2 || bus.Dout[31:0] !== 32'h0) begin failures++;
            $display("FAIL zero_count got_cnt=%0d got_d0=%h exp_cnt=2 exp_d0=0", bus.WrCount, bus.Dout[31:0]); end
        checks++; if (nb.Rdata1 !== 32'hFFFFFFFF || nb.WrCount !== 16'd3) begin failures++;
            $display("FAIL zero_plain got=%h cnt=%0d exp=ffffffff cnt=3", nb.Rdata1, nb.WrCount); end
    endtask

    task automatic test_bypass();
        drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd7, 5'd7);
        step();
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 4'hF, 1'b0, 5'd0, 5'd0);
        #1;
        checks++; if (bus.Rdata1 !== 32'hA5A5A5A5 || bus.Rdata2 !== 32'hA5A5A5A5) begin failures++;
            $display("FAIL bypass_rdata got=%h/%h exp=a5a5a5a5", bus.Rdata1, bus.Rdata2); end
        checks++; if (bus.Dout[255:224] !== 32'h0) begin failures++; $display("FAIL bypass_dout7_pre got=%h exp=0", bus.Dout[255:224]); end
        checks++; if (nb.Rdata1 !== 32'h0 || nb.Rdata2 !== 32'h0) begin failures++;
            $display("FAIL nobypass_pre got=%h/%h exp=0/0", nb.Rdata1, nb.Rdata2); end
        step();
        idle();
        checks++; if (bus.Dout[255:224] !== 32'hA5A5A5A5) begin failures++; $display("FAIL bypass_dout7_post got=%h exp=a5a5a5a5", bus.Dout[255:224]); end
        checks++; if (nb.Rdata1 !== 32'hA5A5A5A5 || nb.Rdata2 !== 32'hA5A5A5A5) begin failures++;
            $display("FAIL nobypass_post got=%h/%h exp=a5a5a5a5", nb.Rdata1, nb.Rdata2); end
    endtask

    task automatic test_reset_midop();
        drive(1'b1, 5'd3, 32'h12345678, 4'hF, 1'b1, 5'd3, 5'd3);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        idle();
        checks++; if (bus.WrCount !== 16'h0 || bus.Dout !== '0) begin failures++;
            $display("FAIL reset_midop got_cnt=%0d exp_cnt=0 dout_nonzero=%0d", bus.WrCount, bus.Dout != '0); end
        checks++; if (nb.WrCount !== 16'h0 || nb.Dout[127:96] !== 32'h0) begin failures++;
            $display("FAIL reset_midop_nb got_cnt=%0d got=%h exp=0", nb.WrCount, nb.Dout[127:96]); end
    endtask

    task automatic test_random();
        int bad_rd = 0, bad_st = 0;
        for (int n = 0; n < 400; n++) begin
            Reset = ($urandom_range(0, 59) == 0);
            drive(1'($urandom), 5'($urandom), 32'($urandom), 4'($urandom), 1'($urandom),
                  5'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) bus.Waddr = bus.Raddr1;
            #1;
            checks++;
            if (bus.Rdata1 !== exp_rd1(ra1) || bus.Rdata2 !== exp_rd1(ra2) ||
                nb.Rdata1 !== m0[ra1] || nb.Rdata2 !== m0[ra2]) begin
                failures++; bad_rd++;
                if (bad_rd < 5) $display("FAIL rand_rdata cyc=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", n,
                    bus.Rdata1, bus.Rdata2, nb.Rdata1, nb.Rdata2, exp_rd1(ra1), exp_rd1(ra2), m0[ra1], m0[ra2]);
            end
            step();
            checks++;
            if (bus.Dout !== exp_dout1() || nb.Dout !== exp_dout0() ||
                bus.WrCount !== 16'(cnt1) || nb.WrCount !== 16'(cnt0)) begin
                failures++; bad_st++;
                if (bad_st < 5) $display("FAIL rand_state cyc=%0d got_cnt=%0d/%0d exp_cnt=%0d/%0d dout_ok=%0d/%0d", n,
                    bus.WrCount, nb.WrCount, cnt1, cnt0, bus.Dout === exp_dout1(), nb.Dout === exp_dout0());
            end
        end
        Reset = 1'b0;
        idle();
    endtask

    task automatic test_saturation();
        idle();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        drive(1'b1, 5'd1, 32'h0000_0001, 4'hF, 1'b0, 5'd0, 5'd0);
        for (int n = 0; n < 65534; n++) step();
        checks++; if (bus.WrCount !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", bus.WrCount); end
        step();
        checks++; if (bus.WrCount !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%h exp=ffff", bus.WrCount); end
        step(); step();
        idle();
        checks++; if (bus.WrCount !== 16'hFFFF || nb.WrCount !== 16'hFFFF) begin failures++;
            $display("FAIL sat_hold got=%h/%h exp=ffff/ffff", bus.WrCount, nb.WrCount); end
        checks++; if (bus.WrCount !== 16'(cnt1)) begin failures++; $display("FAIL sat_model got=%h exp=%h", bus.WrCount, 16'(cnt1)); end
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        for (int i = 0; i < 32; i++) begin m1[i] = 32'h0; m0[i] = 32'h0; end
        ra1 = 5'd0; ra2 = 5'd0; cnt1 = 0; cnt0 = 0;
        @(negedge Clk);
        test_reset();
        test_full_write();
        test_partial_write();
        test_zero_reg();
        test_bypass();
        test_reset_midop();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_rw.md
Name: regfile_rw

Overview:
- Register storage with 2^SEL entries of BUS_WIDTH bits each.
- Sits directly upstream of the 32:1 read multiplexer. It drives the flat concatenated bus that the multiplexer selects from.
- It also exposes two registered-address read ports, and has one synchronous write port with byte enables and an optional write-to-read bypass.
- Used as the processor's general-purpose register file feeding decode/execute.

Parameters:
- BUS_WIDTH, 32: bits per register; must be a multiple of 8.
- SEL, 5: address bits; depth = 2^SEL.
- ZERO_REG, 1: 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1: 1 = a read port addressing the register being written this cycle returns the new data (write-first); 0 = it returns the old contents (read-first).

Ports:
- Clk  input  1  rising-edge clock for all state.
- Reset  input  1  synchronous, active-high; clears all state.
- Wen  input  1  write strobe.
- Waddr  input  SEL  write address.
- Wdata  input  BUS_WIDTH  write data.
- Wbe  input  BUS_WIDTH/8  byte enables; bit k controls Wdata[8k+7:8k].
- Raddr1  input  SEL  read port 1 address.
- Raddr2  input  SEL  read port 2 address.
- Ren  input  1  read-address capture enable.
- Rdata1  output  BUS_WIDTH  read port 1 data.
- Rdata2  output  BUS_WIDTH  read port 2 data.
- Dout  output  BUS_WIDTH*2^SEL  flat bus; entry i occupies Dout[i*BUS_WIDTH +: BUS_WIDTH].
- WrCount  output  16  count of committed writes, saturating.

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset). Nothing happens asynchronously.
- Reset (Reset=1 at a rising edge):
  - all entries = 0; captured read addresses = 0; WrCount = 0.
  - Rdata1, Rdata2 and Dout are therefore 0 in the cycle after reset.
  - Reset has priority over any concurrent Wen/Ren. A write presented in the reset cycle is discarded and not counted.
- Write (Wen=1, Reset=0, rising edge):
  - for each k with Wbe[k]=1, entry[Waddr] byte k <= Wdata byte k; bytes with Wbe[k]=0 keep their value.
  - Wen=1 with Wbe=0 changes no storage and does not increment WrCount.
  - ZERO_REG=1 and Waddr=0: storage is unchanged and WrCount is not incremented.
  - Otherwise a committed write increments WrCount by 1. It saturates at 16'hFFFF: no wrap.
- Read addresses:
  - on a rising edge with Ren=1, ra1_q <= Raddr1 and ra2_q <= Raddr2.
  - With Ren=0 they hold. Reads are therefore stable across decode stalls.
- Read data (combinational from ra1_q/ra2_q and storage):
  - Rdata1 = entry[ra1_q]; Rdata2 likewise for ra2_q.
  - ZERO_REG=1 and address 0: data is 0.
  - Latency: address presented with Ren at edge N -> data valid after edge N, i.e. one cycle of address latency.
- Bypass:
  - applies when BYPASS=1, Wen=1, Waddr==ra?_q, the address is non-zero (or ZERO_REG=0), and Reset=0.
  - Rdata? = merge(entry, Wdata, Wbe) in the same cycle, before the edge commits it.
  - With BYPASS=0, Rdata shows the old value until the edge.
  - Both ports may bypass simultaneously and may address the same entry.
- Dout:
  - always reflects committed storage, never bypassed data.
  - Entry 0 slice is 0 when ZERO_REG=1.
- Width rules:
  - no arithmetic other than WrCount.
  - Out-of-range addresses are impossible: depth = 2^SEL exactly.

Test Plan:
- Reset then idle: Reset=1 for 2 cycles -> Dout=0, Rdata1=Rdata2=0, WrCount=0.
- Full write: Wen=1, Waddr=5, Wdata=32'hDEADBEEF, Wbe=4'hF; then Ren=1, Raddr1=5 -> Rdata1=32'hDEADBEEF one cycle later, Dout[191:160]=32'hDEADBEEF, WrCount=1.
- Partial write: reg 5 holds 32'hDEADBEEF; write Wdata=32'h11223344 with Wbe=4'b0101 -> entry 5 = 32'hDE22BE44.
- Zero register: ZERO_REG=1; write 32'hFFFFFFFF to addr 0, then read addr 0 on both ports -> Rdata1=Rdata2=0, WrCount unchanged.
- Bypass: ra1_q=ra2_q=7 and entry 7=0. Same cycle Wen=1, Waddr=7, Wdata=32'hA5A5A5A5, Wbe=4'hF:
  - BYPASS=1 -> Rdata1=Rdata2=32'hA5A5A5A5 before the edge, Dout slice 7 still 0 until after the edge.
  - BYPASS=0 -> Rdata shows 0 until after the edge.
- Reset mid-operation and saturation:
  - Wen=1 with Reset=1 -> no write, WrCount=0.
  - Force 65536 committed writes -> WrCount=16'hFFFF and it stays there on further writes.
